updi_instr_handler: RTL and testbench



---
 rtl/updi_instr_handler.sv | 117 +++++++++++
 tb/tb_updi_instr_handler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_instr_handler.sv
// rtl/updi_instr_handler.sv - UPDI instruction serializer into the UART TX FIFO
// Emits SYNCH, opcode and payload bytes, pausing on FIFO full and on per-byte ACK waits.
module updi_instr_handler #(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      ready,
    output logic                      waiting_for_ack,
    input  logic                      ack_received,
    input  logic [7:0]                opcode,
    input  logic [7:0]                data [MAX_DATA_SIZE],
    input  logic [DATA_ADDR_BITS-1:0] data_len,
    input  logic [MAX_DATA_SIZE-1:0]  wait_ack_after,
    output logic [7:0]                fifo_data,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full
);

    localparam int IDX_W = DATA_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNCH,
        ST_OPCODE,
        ST_DATA,
        ST_WAIT_ACK
    } state_t;

    state_t                    state, state_d;
    logic [IDX_W-1:0]          idx, idx_d;
    logic [7:0]                op_q;
    logic [7:0]                data_q [MAX_DATA_SIZE];
    logic [DATA_ADDR_BITS-1:0] len_q;
    logic [MAX_DATA_SIZE-1:0]  wait_q;
    logic                      load;
    logic                      last;
    logic [DATA_ADDR_BITS-1:0] sel;

    assign sel  = idx[DATA_ADDR_BITS-1:0];
    // Extra index bit keeps the compare exact even when data_len is at its maximum.
    assign last = (idx + IDX_W'(1)) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            op_q   <= '0;
            len_q  <= '0;
            wait_q <= '0;
            data_q <= '{default: '0};
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (load) begin
                op_q   <= opcode;
                len_q  <= data_len;
                wait_q <= wait_ack_after;
                data_q <= data;
            end
        end
    end

    always_comb begin
        state_d         = state;
        idx_d           = idx;
        load            = 1'b0;
        ready           = 1'b0;
        waiting_for_ack = 1'b0;
        fifo_wr_en      = 1'b0;
        fifo_data       = 8'h00;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SYNCH;
                end
            end
            ST_SYNCH: begin
                fifo_data  = 8'h55;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) state_d = ST_OPCODE;
            end
            ST_OPCODE: begin
                fifo_data  = op_q;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) state_d = (len_q == '0) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                fifo_data  = data_q[sel];
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    if (wait_q[sel])  state_d = ST_WAIT_ACK;
                    else if (last)    state_d = ST_IDLE;
                    else              idx_d   = idx + IDX_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                waiting_for_ack = 1'b1;
                if (ack_received) begin
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_updi_instr_handler.sv
// tb/tb_updi_instr_handler.sv - directed vector bench for updi_instr_handler
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.
module tb_updi_instr_handler;

    localparam int MDS = 16;
    localparam int AB  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           ready;
    logic           waiting_for_ack;
    logic           ack_received = 1'b0;
    logic [7:0]     opcode = 8'h00;
    logic [7:0]     data_in [MDS];
    logic [AB-1:0]  data_len = '0;
    logic [MDS-1:0] wait_ack_after = '0;
    logic [7:0]     fifo_data;
    logic           fifo_wr_en;
    logic           fifo_full;

    // Simple FIFO occupancy model: depth 3 when limited, so the payload stall is reached.
    logic force_full = 1'b0;
    logic depth_lim  = 1'b0;
    int   wr_total   = 0;
    int   rd_total   = 0;
    assign fifo_full = force_full | (depth_lim && ((wr_total - rd_total) >= 3));

    logic       wr_s = 1'b0;
    logic [7:0] by_s = 8'h00;
    logic [7:0] cap [$];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  op;
        int          len;
        logic [15:0] wt;
        logic [7:0]  d [16];
        int          exp_cycles;
    } vec_t;

    vec_t vecs [4];

    updi_instr_handler #(.MAX_DATA_SIZE(MDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ready          (ready),
        .waiting_for_ack(waiting_for_ack),
        .ack_received   (ack_received),
        .opcode         (opcode),
        .data           (data_in),
        .data_len       (data_len),
        .wait_ack_after (wait_ack_after),
        .fifo_data      (fifo_data),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_full      (fifo_full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_s = fifo_wr_en;
        by_s = fifo_data;
    end

    always @(posedge clk) begin
        if (wr_s) begin
            cap.push_back(by_s);
            wr_total <= wr_total + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int cap_at(input int i);
        if (i < cap.size()) return int'(cap[i]);
        return -1;
    endfunction

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int base;
        int cyc;
        int ex;
        base           = cap.size();
        opcode         = v.op;
        data_in        = v.d;
        data_len       = AB'(v.len);
        wait_ack_after = v.wt;
        start          = 1'b1;
        tick();
        start  = 1'b0;
        opcode = ~v.op;
        for (int k = 0; k < MDS; k++) data_in[k] = ~v.d[k];
        wait_ack_after = ~v.wt;
        wait_ready(cyc);
        chk($sformatf("vec%0d cycles", n), cyc, v.exp_cycles);
        chk($sformatf("vec%0d count", n), cap.size() - base, v.len + 2);
        for (int k = 0; k < v.len + 2; k++) begin
            ex = (k == 0) ? 32'h55 : (k == 1) ? int'(v.op) : int'(v.d[k-2]);
            chk($sformatf("vec%0d byte%0d", n, k), cap_at(base + k), ex);
        end
    endtask

    initial begin
        int base;
        int cyc;

        vecs[0].op = 8'hE5; vecs[0].len = 0;  vecs[0].wt = 16'h0000; vecs[0].exp_cycles = 2;
        vecs[0].d  = '{default: 8'h00};
        vecs[1].op = 8'hA0; vecs[1].len = 1;  vecs[1].wt = 16'h0000; vecs[1].exp_cycles = 3;
        vecs[1].d  = '{default: 8'h00};
        vecs[1].d[0] = 8'h11;
        // Bits at and above data_len must be ignored.
        vecs[2].op = 8'h3C; vecs[2].len = 3;  vecs[2].wt = 16'hFFF8; vecs[2].exp_cycles = 5;
        vecs[2].d  = '{default: 8'h00};
        vecs[2].d[0] = 8'hDE; vecs[2].d[1] = 8'hAD; vecs[2].d[2] = 8'hBE;
        vecs[3].op = 8'h69; vecs[3].len = 15; vecs[3].wt = 16'h0000; vecs[3].exp_cycles = 17;
        vecs[3].d  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                       8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        data_in = '{default: 8'h00};

        tick();
        tick();
        chk("reset ready", ready, 1);
        chk("reset waiting", waiting_for_ack, 0);
        chk("reset wr_en", fifo_wr_en, 0);
        chk("reset data", fifo_data, 8'h00);
        rst = 1'b0;
        tick();

        for (int n = 0; n < 4; n++) run_vec(n, vecs[n]);

        // Shallow FIFO with ACK waits after data[1] and data[3].
        depth_lim = 1'b1;
        rd_total  = wr_total;
        base      = cap.size();
        opcode    = 8'h45;
        data_in   = '{default: 8'h00};
        data_in[0] = 8'h12; data_in[1] = 8'h34; data_in[2] = 8'h56; data_in[3] = 8'h78;
        data_len       = 4'd4;
        wait_ack_after = 16'h000A;
        start          = 1'b1;
        tick();
        start = 1'b0;
        chk("ready falls on start", ready, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("stall wr_en", fifo_wr_en, 0);
        chk("stall data held", fifo_data, 8'h34);
        chk("stall count", cap.size() - base, 3);
        chk("stall waiting", waiting_for_ack, 0);
        rd_total = wr_total;
        #1;
        chk("drain wr_en", fifo_wr_en, 1);
        tick();
        chk("ack1 waiting", waiting_for_ack, 1);
        for (int k = 0; k < 5; k++) tick();
        chk("ack1 idle count", cap.size() - base, 4);
        chk("ack1 ready", ready, 0);
        chk("ack1 still waiting", waiting_for_ack, 1);
        chk("ack1 wr_en", fifo_wr_en, 0);
        ack_received = 1'b1;
        tick();
        ack_received = 1'b0;
        chk("after ack wr_en", fifo_wr_en, 1);
        chk("after ack data", fifo_data, 8'h56);
        tick();
        chk("byte3 data", fifo_data, 8'h78);
        tick();
        chk("ack2 waiting", waiting_for_ack, 1);
        chk("ack2 ready", ready, 0);
        ack_received = 1'b1;
        tick();
        ack_received = 1'b0;
        chk("final ack ready", ready, 1);
        chk("ack seq count", cap.size() - base, 6);
        chk("ack seq b0", cap_at(base + 0), 8'h55);
        chk("ack seq b1", cap_at(base + 1), 8'h45);
        chk("ack seq b2", cap_at(base + 2), 8'h12);
        chk("ack seq b3", cap_at(base + 3), 8'h34);
        chk("ack seq b4", cap_at(base + 4), 8'h56);
        chk("ack seq b5", cap_at(base + 5), 8'h78);
        depth_lim = 1'b0;
        tick();

        // start and ack_received pulsed while sending payload must be ignored.
        base           = cap.size();
        opcode         = 8'h4A;
        data_in        = '{default: 8'h00};
        data_in[0] = 8'hAA; data_in[1] = 8'hBB; data_in[2] = 8'hCC;
        data_len       = 4'd3;
        wait_ack_after = 16'h0000;
        start          = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start        = 1'b1;
        opcode       = 8'h99;
        ack_received = 1'b1;
        tick();
        start        = 1'b0;
        ack_received = 1'b0;
        wait_ready(cyc);
        chk("ignore ready", ready, 1);
        for (int k = 0; k < 3; k++) tick();
        chk("ignore count", cap.size() - base, 5);
        chk("ignore b1", cap_at(base + 1), 8'h4A);
        chk("ignore b2", cap_at(base + 2), 8'hAA);
        chk("ignore b3", cap_at(base + 3), 8'hBB);
        chk("ignore b4", cap_at(base + 4), 8'hCC);

        // Reset mid-payload, with start held high on the reset edge.
        opcode         = 8'h22;
        data_in        = '{default: 8'h00};
        data_in[0] = 8'h01; data_in[1] = 8'h02; data_in[2] = 8'h03; data_in[3] = 8'h04;
        data_len       = 4'd4;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst ready", ready, 1);
        chk("rst wr_en", fifo_wr_en, 0);
        chk("rst data", fifo_data, 8'h00);
        base = cap.size();
        tick();
        tick();
        chk("rst no writes", cap.size() - base, 0);
        chk("rst beats start", ready, 1);
        run_vec(9, vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
